tx_serial_7e2: RTL and testbench

//  Asynchronous serial transmitter, 7 data bits, even parity, 2 stop bits (7E2), LSB first.

---
 rtl/tx_serial_pkg.sv | 15 +
 rtl/tx_tick_gen.sv | 30 +++
 rtl/tx_serial_7e2.sv | 108 ++++++++++
 tb/tb_tx_serial_7e2.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/tx_serial_pkg.sv
// Shared definitions for the 7-bit asynchronous serial transmitter:
// FSM state encodings (also shown on db_estado), frame length and line idle level.
package tx_serial_pkg;

  typedef enum logic [3:0] {
    INICIAL     = 4'b0000,
    PREPARACAO  = 4'b0001,
    TRANSMISSAO = 4'b0010,
    FINAL_TX    = 4'b0011
  } estado_t;

  localparam int   FRAME_BITS = 11;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/tx_tick_gen.sv
// Bit-time counter: counts 0..DIVISOR-1 while conta is high and pulses fim_bit
// on the last cycle of each bit period; zera clears it before a frame.
module tx_tick_gen #(
  parameter int DIVISOR = 5208,
  parameter int CNT_W   = 13
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim_bit
);

  localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(DIVISOR - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (zera) begin
      cnt <= '0;
    end else if (conta) begin
      cnt <= (cnt == ULTIMO) ? '0 : cnt + 1'b1;
    end
  end

  assign fim_bit = conta && (cnt == ULTIMO);

endmodule

// File: rtl/tx_serial_7e2.sv
// 7E2 asynchronous serial transmitter, LSB first, with one-cycle pronto after the frame.
// Define TX_PARIDADE_IMPAR_EN to send odd parity instead of even.
module tx_serial_7e2
  import tx_serial_pkg::*;
#(
  parameter int DIVISOR = 5208,
  parameter int CNT_W   = 13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       partida,
  input  logic [6:0] dados_ascii,
  output logic       saida_serial,
  output logic       pronto,
  output logic       ocupado,
  output logic [3:0] db_estado
);

  estado_t               estado;
  logic [FRAME_BITS-1:0] shift;
  logic [3:0]            bit_cnt;
  logic [6:0]            dados_reg;
  logic                  par;
  logic                  zera;
  logic                  conta;
  logic                  fim_bit;

`ifdef TX_PARIDADE_IMPAR_EN
  assign par = ~^dados_reg;
`else
  assign par = ^dados_reg;
`endif

  assign zera      = (estado == PREPARACAO);
  assign conta     = (estado == TRANSMISSAO);
  assign db_estado = estado;

  tx_tick_gen #(
    .DIVISOR (DIVISOR),
    .CNT_W   (CNT_W)
  ) u_tick (
    .clock   (clock),
    .reset   (reset),
    .zera    (zera),
    .conta   (conta),
    .fim_bit (fim_bit)
  );

  // Outputs are registered alongside the state, so the line value is set on the
  // same edge that enters each state or shifts to the next bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado       <= INICIAL;
      saida_serial <= IDLE_LEVEL;
      pronto       <= 1'b0;
      ocupado      <= 1'b0;
      shift        <= '1;
      bit_cnt      <= '0;
      dados_reg    <= '0;
    end else begin
      case (estado)
        INICIAL: begin
          saida_serial <= IDLE_LEVEL;
          pronto       <= 1'b0;
          if (partida) begin
            dados_reg <= dados_ascii;
            ocupado   <= 1'b1;
            estado    <= PREPARACAO;
          end
        end
        PREPARACAO: begin
          shift        <= {IDLE_LEVEL, IDLE_LEVEL, par, dados_reg, 1'b0};
          bit_cnt      <= '0;
          saida_serial <= 1'b0;
          estado       <= TRANSMISSAO;
        end
        TRANSMISSAO: begin
          if (fim_bit) begin
            shift <= {IDLE_LEVEL, shift[FRAME_BITS-1:1]};
            if (bit_cnt != 4'(FRAME_BITS)) begin
              bit_cnt <= bit_cnt + 1'b1;
            end
            if (bit_cnt == 4'(FRAME_BITS - 1)) begin
              saida_serial <= IDLE_LEVEL;
              pronto       <= 1'b1;
              estado       <= FINAL_TX;
            end else begin
              saida_serial <= shift[1];
            end
          end
        end
        FINAL_TX: begin
          saida_serial <= IDLE_LEVEL;
          pronto       <= 1'b0;
          ocupado      <= 1'b0;
          estado       <= INICIAL;
        end
        default: begin
          saida_serial <= IDLE_LEVEL;
          pronto       <= 1'b0;
          ocupado      <= 1'b0;
          estado       <= INICIAL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_serial_7e2.sv
// Bench for tx_serial_7e2 with DIVISOR=4: frame-level reference model plus table of known frames.
module tb_tx_serial_7e2;

  localparam int DIV  = 4;
  localparam int NB   = 11;
  localparam int LAST = 1 + NB * DIV;

  logic       clock;
  logic       reset;
  logic       partida;
  logic [6:0] dados_ascii;
  logic       saida_serial;
  logic       pronto;
  logic       ocupado;
  logic [3:0] db_estado;

  int vectors;
  int miscompares;

  // Reference model: t = cycles since acceptance (-1 when idle), frame under transmission.
  int          t;
  logic [10:0] mframe;

  typedef struct {
    logic [6:0]  d;
    logic        noise;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl[5];

  tx_serial_7e2 #(
    .DIVISOR (DIV),
    .CNT_W   (3)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .partida      (partida),
    .dados_ascii  (dados_ascii),
    .saida_serial (saida_serial),
    .pronto       (pronto),
    .ocupado      (ocupado),
    .db_estado    (db_estado)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [10:0] frame_of(input logic [6:0] d);
    logic [10:0] f;
    int ones;
    ones = 0;
    for (int i = 0; i < 7; i++) ones += int'(d[i]);
    f[0] = 1'b0;
    for (int i = 0; i < 7; i++) f[i+1] = d[i];
`ifdef TX_PARIDADE_IMPAR_EN
    f[8] = (ones % 2 == 0);
`else
    f[8] = (ones % 2 == 1);
`endif
    f[9]  = 1'b1;
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic       el, ep, eo;
    logic [3:0] ee;
    if (t < 0) begin
      el = 1'b1; ep = 1'b0; eo = 1'b0; ee = 4'd0;
    end else if (t == 0) begin
      el = 1'b1; ep = 1'b0; eo = 1'b1; ee = 4'd1;
    end else if (t < LAST) begin
      el = mframe[(t-1)/DIV]; ep = 1'b0; eo = 1'b1; ee = 4'd2;
    end else begin
      el = 1'b1; ep = 1'b1; eo = 1'b1; ee = 4'd3;
    end
    chk("saida_serial", 16'(saida_serial), 16'(el));
    chk("pronto",       16'(pronto),       16'(ep));
    chk("ocupado",      16'(ocupado),      16'(eo));
    chk("db_estado",    16'(db_estado),    16'(ee));
  endtask

  task automatic cycle(input logic p, input logic [6:0] d);
    @(negedge clock);
    partida     = p;
    dados_ascii = d;
    @(posedge clock);
    if (!reset) t = -1;
    else if (t < 0) begin
      if (p) begin
        t = 0;
        mframe = frame_of(d);
      end
    end else if (t == LAST) t = -1;
    else t++;
    #1;
    check_model();
  endtask

  // Sends one frame from idle; observes line at mid-bit, pronto latency and pulse count.
  task automatic run_frame(input logic [6:0] d, input logic noise,
                           output logic [10:0] cap, output int lat, output int npr);
    int start;
    start = -1;
    lat   = -1;
    npr   = 0;
    cap   = '0;
    cycle(1'b1, d);
    for (int c = 1; c < 60; c++) begin
      cycle(noise && (c == 10 || c == 20 || c == 46), noise ? 7'h7F : d);
      if (start < 0 && saida_serial == 1'b0 && db_estado == 4'd2) start = c;
      if (start >= 0 && (c - start) % DIV == 2 && (c - start) / DIV < NB)
        cap[(c - start) / DIV] = saida_serial;
      if (pronto) begin
        npr++;
        lat = (start < 0) ? -1 : c - start;
      end
    end
  endtask

  initial begin
    logic [10:0] cap;
    int          lat;
    int          npr;
    int          npr_model;

    vectors     = 0;
    miscompares = 0;
    t           = -1;
    mframe      = '1;
    partida     = 1'b0;
    dados_ascii = '0;

    tbl[0] = '{7'h41, 1'b0, 11'b11010000010};
    tbl[1] = '{7'h43, 1'b0, 11'b11110000110};
    tbl[2] = '{7'h41, 1'b1, 11'b11010000010};
    tbl[3] = '{7'h55, 1'b0, 11'b11010101010};
    tbl[4] = '{7'h7F, 1'b0, 11'b11111111110};
`ifdef TX_PARIDADE_IMPAR_EN
    for (int i = 0; i < 5; i++) tbl[i].exp = tbl[i].exp ^ 11'h100;
`endif

    // Reset, then an idle stretch with a second reset pulse
    reset = 1'b0;
    #23;
    check_model();
    @(negedge clock);
    reset = 1'b1;
    repeat (3) cycle(1'b0, 7'h00);
    #2 reset = 1'b0;
    #1 check_model();
    @(negedge clock);
    reset = 1'b1;
    cycle(1'b0, 7'h00);

    // Known frames from the table
    for (int i = 0; i < 5; i++) begin
      run_frame(tbl[i].d, tbl[i].noise, cap, lat, npr);
      chk($sformatf("frame[%0d]", i), 16'(cap), 16'(tbl[i].exp));
      chk($sformatf("latency[%0d]", i), 16'(lat), 16'(NB * DIV));
      chk($sformatf("pronto_count[%0d]", i), 16'(npr), 16'd1);
    end

    // partida held high: back-to-back frames, one idle cycle between them
    npr = 0;
    npr_model = 0;
    for (int c = 0; c < 3 * (LAST + 2); c++) begin
      cycle(1'b1, 7'h2A);
      if (pronto) npr++;
      if (t == LAST) npr_model++;
    end
    chk("held_pronto_count", 16'(npr), 16'(npr_model));
    chk("held_frames", 16'(npr_model), 16'd3);
    repeat (LAST + 2) cycle(1'b0, 7'h00);

    // Reset during data bit 3: line back to idle immediately, no pronto
    cycle(1'b1, 7'h41);
    while (t >= 0 && t < 1 + 4 * DIV + 1) cycle(1'b0, 7'h41);
    chk("bit3_before_reset", 16'(saida_serial), 16'(1'b0));
    #2 reset = 1'b0;
    t = -1;
    #1;
    chk("async_line_idle", 16'(saida_serial), 16'(1'b1));
    check_model();
    npr = 0;
    repeat (4) begin
      cycle(1'b0, 7'h41);
      if (pronto) npr++;
    end
    chk("no_pronto_after_reset", 16'(npr), 16'd0);
    @(negedge clock);
    reset = 1'b1;
    cycle(1'b0, 7'h00);
    run_frame(7'h43, 1'b0, cap, lat, npr);
    chk("frame_after_reset", 16'(cap), 16'(tbl[1].exp));
    chk("latency_after_reset", 16'(lat), 16'(NB * DIV));
    chk("pronto_after_reset", 16'(npr), 16'd1);

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      cycle($urandom_range(0, 9) == 0, 7'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
